// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command bytes and parity helper. Rev 1.0
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    STOP      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    ERR       = 3'd6
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  localparam int unsigned PS2_CNT_W = 20;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer, FILTER_LEN-sample glitch filter and fall pulse. Rev 1.0
`default_nettype none

module ps2_line_sync #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;
  logic                  filt_d;
  logic                  fall_q;

  // The filtered level only moves once the whole history window agrees.
  always_comb begin
    filt_d = filt_q;
    if (&hist_q)       filt_d = 1'b1;
    else if (~|hist_q) filt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      hist_q <= '1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      filt_q <= filt_d;
      fall_q <= filt_q & ~filt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter, open-drain via oe pins. Rev 1.0
// Build option: PS2_HOST_TX_RETRY_EN adds up to 2 automatic retries on NACK/timeout.
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [PS2_CNT_W-1:0] INH_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_CNT_W-1:0] TO_LAST  = PS2_CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e           state_q, state_d;
  logic [PS2_CNT_W-1:0] cnt_q, cnt_d, w_cnt_inc;
  logic [8:0]           shift_q, shift_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 data_oe_q, data_oe_d;
  logic                 data_meta_q, data_sync_q;
  logic                 clk_filt, clk_fall;
  logic                 w_inh_last, w_timeout;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [7:0]           byte_q, byte_d;
  logic [1:0]           retry_q, retry_d;
`endif

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_in),
    .filt_o (clk_filt),
    .fall_o (clk_fall)
  );

  assign w_cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign w_inh_last = (state_q == INHIBIT) && (cnt_q == INH_LAST);
  assign w_timeout  = ((state_q == REQ) || (state_q == STOP) ||
                       (state_q == ACK) || (state_q == WAIT_IDLE)) && (cnt_q >= TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    data_oe_d = data_oe_q;
    tx_done   = 1'b0;
    tx_err    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    byte_d    = byte_q;
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d  = INHIBIT;
          cnt_d    = '0;
          shift_d  = {odd_parity(tx_data), tx_data};
          bitcnt_d = '0;
`ifdef PS2_HOST_TX_RETRY_EN
          byte_d   = tx_data;
          retry_d  = '0;
`endif
        end
      end
      INHIBIT: begin
        cnt_d = w_cnt_inc;
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
          cnt_d     = '0;
        end
      end
      REQ: begin
        cnt_d = w_cnt_inc;
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd8) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = w_cnt_inc;
        if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        cnt_d = w_cnt_inc;
        if (clk_fall) state_d = data_sync_q ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d = w_cnt_inc;
        if (clk_filt && data_sync_q) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        if (retry_q != 2'd2) begin
          retry_d  = retry_q + 2'd1;
          state_d  = INHIBIT;
          cnt_d    = '0;
          shift_d  = {odd_parity(byte_q), byte_q};
          bitcnt_d = '0;
        end else begin
          tx_err  = 1'b1;
          state_d = IDLE;
        end
`else
        tx_err  = 1'b1;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // The timeout wins over any bus event seen in the same cycle.
    if (w_timeout) begin
      state_d   = ERR;
      data_oe_d = 1'b0;
      tx_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      data_oe_q   <= 1'b0;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
      byte_q      <= '0;
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      data_oe_q   <= data_oe_d;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
`ifdef PS2_HOST_TX_RETRY_EN
      byte_q      <= byte_d;
      retry_q     <= retry_d;
`endif
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = ~tx_ready;
  assign rx_inhibit  = busy;
  assign ps2_clk_oe  = (state_q == INHIBIT);
  assign ps2_data_oe = data_oe_q | w_inh_last;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model for ps2_host_tx. Rev 1.0
`default_nettype none

module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 5000;
  localparam int unsigned TO  = 2000;
  localparam int unsigned FLT = 4;
  localparam int          H   = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int NTRY = 3;
`else
  localparam int NTRY = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy, rx_inhibit;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data_in = ~(ps2_data_oe | dev_data_low);

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int inh_cnt = 0;
  int inh_run = 0;
  int last_inh = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .busy        (busy),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Pulse counters and inhibit-length tracker.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
    if (ps2_clk_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      last_inh <= inh_run;
      inh_cnt  <= inh_cnt + 1;
      inh_run  <= 0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    chk_eq("ready_before_send", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk_eq("busy_after_accept", 32'(busy), 1);
    chk_eq("rx_inhibit_after_accept", 32'(rx_inhibit), 1);
  endtask

  task automatic dev_clock(output logic b);
    dev_clk_low = 1'b1;
    tick(H);
    b = ps2_data_in;
    dev_clk_low = 1'b0;
    tick(H);
  endtask

  task automatic wait_req(output bit ok);
    int start;
    int n;
    start = inh_cnt;
    n = 0;
    while (inh_cnt == start && n < 3 * int'(INH)) begin
      tick(1);
      n++;
    end
    ok = (inh_cnt != start);
    chk_eq("req_reached", 32'(ok), 1);
    chk_eq("inhibit_len", 32'(last_inh), INH);
    chk_eq("start_bit_oe", 32'(ps2_data_oe), 1);
    chk_eq("clk_released", 32'(ps2_clk_oe), 0);
  endtask

  // Device side of one frame; abort_at >= 0 leaves the clock low during that bit.
  task automatic run_frame(input logic [7:0] b, input logic par, input bit ack, input int abort_at);
    logic [9:0] bits;
    logic       bv;
    bit         ok;
    bits = '0;
    wait_req(ok);
    if (!ok) return;
    tick(H);
    for (int k = 0; k < 10; k++) begin
      if (k == abort_at) begin
        dev_clk_low = 1'b1;
        tick(H / 2);
        return;
      end
      dev_clock(bv);
      bits[k] = bv;
    end
    chk_eq("data_bits", 32'(bits[7:0]), 32'(b));
    chk_eq("parity_bit", 32'(bits[8]), 32'(par));
    chk_eq("stop_bit", 32'(bits[9]), 1);
    dev_data_low = ack;
    tick(4);
    dev_clock(bv);
    dev_data_low = 1'b0;
  endtask

  initial begin
    logic [7:0] vb [3];
    logic       vp [3];
    int         d0, e0, c, ic;
    bit         ok;

    vb[0] = PS2_CMD_SET_LED; vp[0] = 1'b1;
    vb[1] = 8'h01;           vp[1] = 1'b0;
    vb[2] = 8'h00;           vp[2] = 1'b1;

    tick(3);
    chk_eq("rst_tx_ready", 32'(tx_ready), 1);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_rx_inhibit", 32'(rx_inhibit), 0);
    chk_eq("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk_eq("rst_data_oe", 32'(ps2_data_oe), 0);
    chk_eq("rst_tx_done", 32'(tx_done), 0);
    chk_eq("rst_tx_err", 32'(tx_err), 0);
    rst = 1'b1;
    tick(5);

    // Good frames, including both parity polarities.
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(vb[i]);
      run_frame(vb[i], vp[i], 1'b1, -1);
      tick(60);
      chk_eq("good_done_pulses", 32'(done_cnt - d0), 1);
      chk_eq("good_err_pulses", 32'(err_cnt - e0), 0);
      chk_eq("good_busy_low", 32'(busy), 0);
      chk_eq("good_ready", 32'(tx_ready), 1);
      chk_eq("good_data_oe", 32'(ps2_data_oe), 0);
    end

    // Device never clocks: error exactly TO cycles after REQ entry.
    d0 = done_cnt;
    e0 = err_cnt;
    send(PS2_CMD_ENABLE);
    for (int t = 0; t < NTRY; t++) begin
      wait_req(ok);
      c = 1;
      while (ps2_data_oe && c < int'(TO) + 50) begin
        tick(1);
        c++;
      end
      chk_eq("timeout_cycles", 32'(c), TO);
      chk_eq("timeout_clk_oe", 32'(ps2_clk_oe), 0);
      chk_eq("timeout_data_oe", 32'(ps2_data_oe), 0);
      chk_eq("timeout_err_level", 32'(tx_err), (t == NTRY - 1) ? 1 : 0);
    end
    tick(10);
    chk_eq("timeout_err_pulses", 32'(err_cnt - e0), 1);
    chk_eq("timeout_done_pulses", 32'(done_cnt - d0), 0);
    chk_eq("timeout_ready", 32'(tx_ready), 1);

    // Missing ack.
    d0 = done_cnt;
    e0 = err_cnt;
    send(PS2_CMD_ENABLE);
    for (int t = 0; t < NTRY; t++) begin
      run_frame(PS2_CMD_ENABLE, 1'b0, 1'b0, -1);
      tick(60);
      if (t < NTRY - 1) chk_eq("retry_busy", 32'(busy), 1);
    end
    chk_eq("nack_err_pulses", 32'(err_cnt - e0), 1);
    chk_eq("nack_done_pulses", 32'(done_cnt - d0), 0);
    chk_eq("nack_ready", 32'(tx_ready), 1);

    // Asynchronous reset while bit 4 (a 0 of 0xA5) is being driven.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5);
    run_frame(8'hA5, 1'b1, 1'b1, 4);
    chk_eq("bit4_driven", 32'(ps2_data_oe), 1);
    #2 rst = 1'b0;
    #1;
    chk_eq("arst_clk_oe", 32'(ps2_clk_oe), 0);
    chk_eq("arst_data_oe", 32'(ps2_data_oe), 0);
    chk_eq("arst_ready", 32'(tx_ready), 1);
    dev_clk_low = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(100);
    chk_eq("post_rst_ready", 32'(tx_ready), 1);
    chk_eq("post_rst_busy", 32'(busy), 0);
    chk_eq("post_rst_done", 32'(done_cnt - d0), 0);
    chk_eq("post_rst_err", 32'(err_cnt - e0), 0);

    // A request while busy is dropped, not queued.
    d0 = done_cnt;
    send(PS2_CMD_RESET);
    tick(100);
    chk_eq("busy_not_ready", 32'(tx_ready), 0);
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    run_frame(PS2_CMD_RESET, 1'b1, 1'b1, -1);
    tick(60);
    chk_eq("ff_done_pulses", 32'(done_cnt - d0), 1);
    ic = inh_cnt;
    tick(300);
    chk_eq("no_queued_frame", 32'(inh_cnt - ic), 0);
    chk_eq("no_queued_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the system to the keyboard over the shared ps2_clk/ps2_data lines.
- Sits beside the PS/2 keyboard receiver on the same two wires.
- Drives the lines open-drain through output-enable pins. Asserts rx_inhibit so the receiver ignores host-generated traffic.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before start (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles from clock release to ack (15 ms at 50 MHz).
- FILTER_LEN, 4: consecutive equal synchronized samples needed to accept a level change on ps2_clk_in.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: request. Accepted when tx_valid && tx_ready.
- tx_ready, out, 1: high only in IDLE.
- tx_done, out, 1: one-cycle pulse on successful ack.
- tx_err, out, 1: one-cycle pulse on timeout or missing ack.
- busy, out, 1: high in every state except IDLE.
- rx_inhibit, out, 1: equals busy. Receiver discards frames while high.
- ps2_clk_in, in, 1: raw clock line (asynchronous).
- ps2_data_in, in, 1: raw data line (asynchronous).
- ps2_clk_oe, out, 1: 1 = pull ps2_clk low, 0 = release.
- ps2_data_oe, out, 1: 1 = pull ps2_data low, 0 = release.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; all outputs 0 except tx_ready=1; both lines released.
  - Reset asserted mid-frame releases both lines immediately, without waiting for a clock edge. The frame is abandoned, no pulse is emitted.
- Input conditioning:
  - ps2_clk_in: 2-FF synchronizer, then FILTER_LEN filter, then a one-cycle fall pulse on each filtered 1->0 transition.
  - ps2_data_in: 2-FF synchronizer only.
- Capture: on accept, latch tx_data into shift[8:0] = {odd parity, tx_data}. Parity = ~^tx_data.
- IDLE:
  - oe=00, tx_ready=1.
  - On accept -> INHIBIT and load the counter.
- INHIBIT:
  - ps2_clk_oe=1 for INHIBIT_CYCLES cycles.
  - In the final cycle, ps2_data_oe goes 1 (start bit).
  - Then -> REQ.
- REQ:
  - ps2_clk_oe=0, ps2_data_oe=1. Start the timeout counter.
  - On each fall: drive ps2_data_oe = ~shift[0], shift right, bitcnt++.
  - The first fall presents data bit0. After 9 falls (8 data bits + parity) -> STOP.
- STOP:
  - On the next fall, release data (ps2_data_oe=0, stop=1) -> ACK.
- ACK:
  - On the next fall, sample synchronized data.
  - 0 -> WAIT_IDLE. 1 -> ERR.
- WAIT_IDLE:
  - Wait until filtered clk=1 and data=1.
  - Then -> IDLE with tx_done pulse.
- ERR:
  - Release lines, tx_err pulse, -> IDLE.
- Timeout:
  - Counter runs from REQ entry through WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES in any of those states -> ERR, regardless of bit position.
- Flow control:
  - tx_valid while busy is ignored, not queued. The caller holds it until tx_ready.
  - tx_done and tx_err are never asserted in the same cycle.
  - Back-to-back: tx_ready returns the cycle after the done/err pulse.
- Counters:
  - Cycle counter is 20 bits wide, saturating.
  - bitcnt is 4 bits wide, cleared on accept.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, re-enter INHIBIT with the same byte, up to 2 retries.
  - tx_err pulses only after the third failure. tx_done pulses on any success.
  - busy stays high throughout the retries.
- Undefined: first failure -> tx_err. No retry logic is synthesized.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, STOP, ACK, WAIT_IDLE, ERR};
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF;
  - odd-parity function.
- Sub-module ps2_line_sync: synchronizer, glitch filter and fall-pulse generator. Also reusable by the receiver.

Test Plan:
- Send 0xED to a device model:
  - ps2_clk held low for 5000 cycles;
  - bits on the falls are 1,0,1,1,0,1,1,1, then parity 1, then stop 1;
  - model acks -> tx_done pulses once, busy drops, tx_ready=1.
- Send 0x01: parity bit 0. Send 0x00: parity bit 1. Model checks both parity bits and both acks.
- Device never clocks -> tx_err exactly TIMEOUT_CYCLES cycles after REQ entry; both oe=0.
- Model leaves data high at the ack clock -> tx_err pulse, no tx_done. With RETRY_EN, 3 full frames are observed before tx_err.
- rst dropped during bit 4 -> ps2_clk_oe=ps2_data_oe=0 asynchronously, tx_ready=1 after release, no pulses.
- tx_valid pulsed with 0xF4 during an active 0xFF frame -> ignored; only 0xFF appears on the bus.
